// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8N1 UART receiver with a 2-FF input synchronizer, mid-bit
// sampling driven by a baud-tick counter, and sticky status flags for the
// consumer (Rx_flag, Rx_frame_error, Rx_overrun).
//
// Consumer handshake: the receiver raises Rx_flag when DataRx_out holds a
// new good byte. The consumer acknowledges with a one-cycle clr_rx_flag
// pulse, which clears Rx_flag and Rx_overrun on the next edge. If a good
// frame completes on that same edge, the new byte wins: Rx_flag stays 1 and
// Rx_overrun is not set.
module uart_rx_unit #(
  parameter int UART_Nbit = 8,
  parameter int baudrate  = 9600,
  parameter int clk_freq  = 50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SerialDataIn,
  input  logic                 clr_rx_flag,
  output logic                 Rx_flag,
  output logic [UART_Nbit-1:0] DataRx_out,
  output logic                 Rx_frame_error,
  output logic                 Rx_overrun,
  output logic                 rx_busy,
  output logic [1:0]           o_dbg_state
);

  localparam int BIT_TICKS  = clk_freq / baudrate;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int TW         = $clog2(BIT_TICKS);
  localparam int IW         = (UART_Nbit > 1) ? $clog2(UART_Nbit) : 1;

  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_Nbit - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [TW-1:0]        r_tick;
  logic [IW-1:0]        r_idx;
  logic [UART_Nbit-1:0] r_shift;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_flag;
  logic [UART_Nbit-1:0] r_data;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 w_rx_s;

  assign w_rx_s = r_sync2;

  // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= SerialDataIn;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM: start detect, mid-bit data sampling, stop check and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_flag  <= 1'b0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // Consumer acknowledge; a good-frame set later in this block overrides it.
      if (clr_rx_flag) begin
        r_flag <= 1'b0;
        r_ovr  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_tick <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (r_tick == HALF_LAST) begin
            // Middle of the start bit: a high line here means it was a glitch.
            r_tick <= '0;
            r_idx  <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        S_DATA: begin
          if (r_tick == BIT_LAST) begin
            // LSB arrives first, so shifting in at the MSB leaves bit 0 at the bottom.
            r_tick  <= '0;
            r_shift <= {w_rx_s, r_shift[UART_Nbit-1:1]};
            if (r_idx == IDX_LAST) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        S_STOP: begin
          if (r_tick == BIT_LAST) begin
            // Leave at mid stop bit so a following start edge is not missed.
            r_tick  <= '0;
            r_state <= S_IDLE;
            if (w_rx_s) begin
              r_data <= r_shift;
              r_flag <= 1'b1;
              r_ferr <= 1'b0;
              if (r_flag && !clr_rx_flag) begin
                r_ovr <= 1'b1;
              end
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
        end
      endcase
    end
  end

  assign Rx_flag        = r_flag;
  assign DataRx_out     = r_data;
  assign Rx_frame_error = r_ferr;
  assign Rx_overrun     = r_ovr;
  assign rx_busy        = (r_state != S_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Testbench for uart_rx_unit with BIT_TICKS=10, HALF_TICKS=5.
// A frame whose start bit is driven right after edge c0 is modelled as a
// completion event at edge c0+98 (2 synchronizer cycles, 1 cycle to leave
// IDLE, 5 to mid start bit, 8 data bits and one stop bit of 10 cycles each),
// and as a busy interval from edge c0+3 up to that completion.
module tb_uart_rx_unit;

  localparam int NB   = 8;
  localparam int BIT  = 10;
  localparam int HALF = 5;
  localparam int DONE = 3 + HALF + NB * BIT + BIT;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          line  = 1'b1;
  logic          clr   = 1'b0;
  logic          rx_flag;
  logic [NB-1:0] rx_data;
  logic          rx_ferr;
  logic          rx_ovr;
  logic          rx_busy;
  logic [1:0]    dbg_state;

  uart_rx_unit #(
    .UART_Nbit (NB),
    .baudrate  (5),
    .clk_freq  (50)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .SerialDataIn   (line),
    .clr_rx_flag    (clr),
    .Rx_flag        (rx_flag),
    .DataRx_out     (rx_data),
    .Rx_frame_error (rx_ferr),
    .Rx_overrun     (rx_ovr),
    .rx_busy        (rx_busy),
    .o_dbg_state    (dbg_state)
  );

  // Clock / reset block: 10 time-unit period; reset is driven by the sequence below.
  always #5 clk = ~clk;

  // Scoreboard state
  typedef struct {
    int            c;
    logic [NB-1:0] d;
    logic          good;
  } ev_t;

  ev_t           exp_q[$];
  int            bs_q[$];
  int            be_q[$];
  int            cyc      = 0;
  int            total    = 0;
  int            bad      = 0;
  logic          exp_flag = 1'b0;
  logic [NB-1:0] exp_data = '0;
  logic          exp_ferr = 1'b0;
  logic          exp_ovr  = 1'b0;
  logic          prev_flag = 1'b0;
  int            rise_cyc = 0;
  int            busy_cnt = 0;
  ev_t           ev_cur;
  logic          ev_dn;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic exp_busy();
    for (int i = 0; i < bs_q.size(); i++) begin
      if (cyc >= bs_q[i] && cyc < be_q[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Behavioural model: applies frame completions and consumer clears per edge.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      bs_q.delete();
      be_q.delete();
      exp_flag = 1'b0;
      exp_data = '0;
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
    end else begin
      ev_dn = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        ev_cur = exp_q.pop_front();
        ev_dn  = 1'b1;
      end
      if (ev_dn && ev_cur.good) begin
        if (exp_flag && !clr) exp_ovr = 1'b1;
        else if (clr)         exp_ovr = 1'b0;
        exp_flag = 1'b1;
        exp_data = ev_cur.d;
        exp_ferr = 1'b0;
      end else begin
        if (ev_dn) exp_ferr = 1'b1;
        if (clr) begin
          exp_flag = 1'b0;
          exp_ovr  = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("rx_flag", {31'd0, rx_flag}, {31'd0, exp_flag});
    check("data_rx_out", {24'd0, rx_data}, {24'd0, exp_data});
    check("rx_frame_error", {31'd0, rx_ferr}, {31'd0, exp_ferr});
    check("rx_overrun", {31'd0, rx_ovr}, {31'd0, exp_ovr});
    check("rx_busy", {31'd0, rx_busy}, {31'd0, exp_busy()});
    check("dbg_state_busy", {31'd0, (dbg_state != 2'd0)}, {31'd0, exp_busy()});
    if (rx_flag && !prev_flag) rise_cyc = cyc;
    prev_flag = rx_flag;
    if (rx_busy) busy_cnt++;
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic send_frame(input logic [NB-1:0] d, input logic stop, output int c0);
    ev_t ev;
    @(posedge clk);
    #1;
    c0      = cyc;
    ev.c    = c0 + DONE;
    ev.d    = d;
    ev.good = stop;
    exp_q.push_back(ev);
    bs_q.push_back(c0 + 3);
    be_q.push_back(c0 + DONE);
    if (!stop) begin
      // The low stop bit is still in the synchronizer when the FSM returns to
      // IDLE, so it reads as a new start edge that is then rejected as a glitch.
      bs_q.push_back(c0 + DONE + 1);
      be_q.push_back(c0 + DONE + 1 + HALF);
    end
    line = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) begin
      line = d[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    line = stop;
    repeat (BIT) @(posedge clk);
    #1;
    line = 1'b1;
  endtask

  int            c0;
  int            lat;
  logic [NB-1:0] pd;

  initial begin
    rst_n = 1'b0;
    line  = 1'b1;
    clr   = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    #1;
    check("reset_flag", {31'd0, rx_flag}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_busy", {31'd0, rx_busy}, 32'd0);
    idle(5);

    // Short low glitch: rejected at mid start bit
    @(posedge clk);
    #1;
    c0 = cyc;
    bs_q.push_back(c0 + 3);
    be_q.push_back(c0 + 3 + HALF);
    busy_cnt = 0;
    line = 1'b0;
    idle(3);
    line = 1'b1;
    idle(20);
    check("glitch_busy_bounded", {31'd0, (busy_cnt > 0 && busy_cnt <= HALF + 1)}, 32'd1);
    check("glitch_flag", {31'd0, rx_flag}, 32'd0);
    check("glitch_data", {24'd0, rx_data}, 32'd0);

    // Good 0xA5 and its latency
    send_frame(8'hA5, 1'b1, c0);
    lat = rise_cyc - c0;
    check("a5_latency_window", {31'd0, (lat >= 96 && lat <= 98)}, 32'd1);
    check("a5_data", {24'd0, rx_data}, 32'hA5);
    check("a5_flag", {31'd0, rx_flag}, 32'd1);
    check("a5_ferr", {31'd0, rx_ferr}, 32'd0);
    pulse_clr();
    idle(2);
    check("clr_flag", {31'd0, rx_flag}, 32'd0);
    idle(10);

    // Frame error keeps the last good byte; next good frame clears the error
    send_frame(8'h11, 1'b1, c0);
    idle(10);
    send_frame(8'h77, 1'b0, c0);
    idle(20);
    check("ferr_set", {31'd0, rx_ferr}, 32'd1);
    check("ferr_data_kept", {24'd0, rx_data}, 32'h11);
    check("ferr_flag_kept", {31'd0, rx_flag}, 32'd1);
    send_frame(8'h22, 1'b1, c0);
    idle(5);
    check("ferr_cleared", {31'd0, rx_ferr}, 32'd0);
    check("good_after_err", {24'd0, rx_data}, 32'h22);
    check("ovr_after_err", {31'd0, rx_ovr}, 32'd1);
    pulse_clr();
    idle(10);

    // Back-to-back frames without acknowledge -> overrun
    send_frame(8'h3C, 1'b1, c0);
    send_frame(8'hC3, 1'b1, c0);
    idle(3);
    check("ovr_set", {31'd0, rx_ovr}, 32'd1);
    check("ovr_data", {24'd0, rx_data}, 32'hC3);
    check("ovr_flag", {31'd0, rx_flag}, 32'd1);
    pulse_clr();
    idle(2);
    check("ovr_clr_flag", {31'd0, rx_flag}, 32'd0);
    check("ovr_clr_ovr", {31'd0, rx_ovr}, 32'd0);
    idle(10);

    // Reset during data bit 4 aborts the frame
    pd = 8'h5A;
    @(posedge clk);
    #1;
    c0 = cyc;
    bs_q.push_back(c0 + 3);
    be_q.push_back(c0 + DONE);
    line = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      line = pd[i];
      idle(BIT);
    end
    line = pd[4];
    repeat (3) @(posedge clk);
    #6 rst_n = 1'b0;
    #1;
    check("mid_reset_flag", {31'd0, rx_flag}, 32'd0);
    check("mid_reset_data", {24'd0, rx_data}, 32'd0);
    check("mid_reset_busy", {31'd0, rx_busy}, 32'd0);
    check("mid_reset_ferr", {31'd0, rx_ferr}, 32'd0);
    line = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b1, c0);
    idle(3);
    check("post_reset_data", {24'd0, rx_data}, 32'h5A);
    check("post_reset_flag", {31'd0, rx_flag}, 32'd1);
    check("post_reset_ferr", {31'd0, rx_ferr}, 32'd0);
    idle(5);

    // Acknowledge on the exact edge of the stop sample: set wins, no overrun
    fork
      send_frame(8'h96, 1'b1, c0);
      begin
        repeat (DONE) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
      end
    join
    idle(3);
    check("same_cycle_flag", {31'd0, rx_flag}, 32'd1);
    check("same_cycle_ovr", {31'd0, rx_ovr}, 32'd0);
    check("same_cycle_data", {24'd0, rx_data}, 32'h96);
    pulse_clr();
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
